// File: rtl/motion_pkg.sv
// Shared definitions for the player motion scheduler: command codes,
// FSM state encoding and the heading width.
package motion_pkg;
  localparam int ANGLE_W = 9;

  localparam logic [7:0] CMD_FORWARD    = 8'd1;
  localparam logic [7:0] CMD_BACKWARD   = 8'd2;
  localparam logic [7:0] CMD_TURN_LEFT  = 8'd3;
  localparam logic [7:0] CMD_TURN_RIGHT = 8'd4;

  typedef enum logic {
    IDLE = 1'b0,
    MOVE = 1'b1
  } state_e;

  function automatic logic is_known_cmd(input logic [7:0] code);
    return (code >= CMD_FORWARD) && (code <= CMD_TURN_RIGHT);
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// Byte-wide synchronous FIFO; a push on a full FIFO is accepted only
// when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);
  logic [7:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/player_motion_ctrl.sv
// Queues SPI command bytes, rate-limits them per frame, applies turns to
// the owned heading and hands moves to the position updater.
module player_motion_ctrl
  import motion_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int CMDS_PER_FRAME = 2,
  parameter int TURN_STEP      = 8,
  parameter int ANGLE_INIT     = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         spi_flag,
  input  logic [7:0]   spi_data,
  input  logic         frame_tick,
  output logic         move_valid,
  output logic [1:0]   move_code,
  input  logic         move_ready,
  output logic [8:0]   player_angle,
  output logic [2:0]   fifo_count,
  output logic         overflow,
  output logic [7:0]   drop_count
);
  localparam int CW = $clog2(CMDS_PER_FRAME + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [2:0]         sync_q, sync_d;
  logic [CW-1:0]      credit_q, credit_d;
  state_e             state_q, state_d;
  logic               move_valid_q, move_valid_d;
  logic [1:0]         move_code_q, move_code_d;
  logic [ANGLE_W-1:0] angle_q, angle_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_q, drop_d;

  logic               byte_tick, fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic               known, dispatch, unk_pop, push_drop;
  logic [7:0]         head;
  logic [AW:0]        count;
  logic [8:0]         drop_sum;

  // sync_q[1] is the synchronized level, sync_q[2] its previous value
  assign sync_d    = {sync_q[1:0], spi_flag};
  assign byte_tick = sync_q[1] & ~sync_q[2];

  assign known     = is_known_cmd(head);
  assign fifo_pop  = (state_q == IDLE) & ~fifo_empty & (~known | (credit_q != '0));
  assign dispatch  = fifo_pop & known;
  assign unk_pop   = fifo_pop & ~known;
  assign push_drop = byte_tick & fifo_full & ~fifo_pop;
  assign fifo_push = byte_tick & ~push_drop;
  assign drop_sum  = {1'b0, drop_q} + 9'(push_drop) + 9'(unk_pop);

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (spi_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_comb begin
    state_d      = state_q;
    move_valid_d = move_valid_q;
    move_code_d  = move_code_q;
    angle_d      = angle_q;
    overflow_d   = overflow_q | push_drop;
    drop_d       = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    credit_d     = frame_tick ? CW'(CMDS_PER_FRAME)
                              : (dispatch ? credit_q - 1'b1 : credit_q);
    case (state_q)
      IDLE: if (dispatch) begin
        case (head)
          CMD_TURN_LEFT:  angle_d = angle_q - ANGLE_W'(TURN_STEP);
          CMD_TURN_RIGHT: angle_d = angle_q + ANGLE_W'(TURN_STEP);
          default: begin
            move_valid_d = 1'b1;
            move_code_d  = head[1:0];
            state_d      = MOVE;
          end
        endcase
      end
      MOVE: if (move_ready) begin
        move_valid_d = 1'b0;
        move_code_d  = 2'd0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q       <= '0;
      credit_q     <= CW'(CMDS_PER_FRAME);
      state_q      <= IDLE;
      move_valid_q <= 1'b0;
      move_code_q  <= 2'd0;
      angle_q      <= ANGLE_W'(ANGLE_INIT);
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      sync_q       <= sync_d;
      credit_q     <= credit_d;
      state_q      <= state_d;
      move_valid_q <= move_valid_d;
      move_code_q  <= move_code_d;
      angle_q      <= angle_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

  assign move_valid   = move_valid_q;
  assign move_code    = move_code_q;
  assign player_angle = angle_q;
  assign fifo_count   = 3'(count);
  assign overflow     = overflow_q;
  assign drop_count   = drop_q;
endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_player_motion_ctrl;
  localparam int D = 4, C = 2, STEP = 8, INIT = 0;

  logic       clk = 0, reset = 0, spi_flag = 0, frame_tick = 0, move_ready = 0;
  logic [7:0] spi_data = 0;
  logic       move_valid, overflow;
  logic [1:0] move_code;
  logic [8:0] player_angle;
  logic [2:0] fifo_count;
  logic [7:0] drop_count;

  int checks = 0, failures = 0;

  // reference model state
  int mq[$];
  int m_credit, m_angle, m_moving, m_code, m_ovf, m_drops, s1, s2, s3;

  player_motion_ctrl #(.FIFO_DEPTH(D), .CMDS_PER_FRAME(C), .TURN_STEP(STEP),
                       .ANGLE_INIT(INIT)) dut (
    .clk(clk), .reset(reset), .spi_flag(spi_flag), .spi_data(spi_data),
    .frame_tick(frame_tick), .move_valid(move_valid), .move_code(move_code),
    .move_ready(move_ready), .player_angle(player_angle), .fifo_count(fifo_count),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  function automatic void model_edge(input bit r, input bit f, input int d,
                                     input bit ft, input bit rdy);
    bit tick, popd, disp;
    int pre_size, c;
    if (r) begin
      mq.delete();
      m_credit = C; m_angle = INIT; m_moving = 0; m_code = 0;
      m_ovf = 0; m_drops = 0; s1 = 0; s2 = 0; s3 = 0;
      return;
    end
    tick = (s2 != 0) && (s3 == 0);
    popd = 0; disp = 0;
    pre_size = mq.size();
    if (!m_moving && mq.size() > 0) begin
      c = mq[0];
      if (c < 1 || c > 4) begin
        popd = 1; void'(mq.pop_front()); m_drops++;
      end else if (m_credit > 0) begin
        popd = 1; disp = 1; void'(mq.pop_front());
        if (c == 3) m_angle = (m_angle + 512 - STEP) % 512;
        else if (c == 4) m_angle = (m_angle + STEP) % 512;
        else begin m_moving = 1; m_code = c; end
      end
    end else if (m_moving && rdy) begin
      m_moving = 0; m_code = 0;
    end
    if (tick) begin
      if (pre_size < D || popd) mq.push_back(d);
      else begin m_ovf = 1; m_drops++; end
    end
    if (m_drops > 255) m_drops = 255;
    m_credit = ft ? C : m_credit - int'(disp);
    s3 = s2; s2 = s1; s1 = int'(f);
  endfunction

  task automatic step();
    bit r, f, ft, rdy;
    int d;
    r = reset; f = spi_flag; ft = frame_tick; rdy = move_ready; d = spi_data;
    @(posedge clk);
    model_edge(r, f, d, ft, rdy);
    #1;
  endtask

  task automatic do_reset();
    spi_flag = 0; frame_tick = 0; move_ready = 0; reset = 1;
    step();
    reset = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_flag = 1; spi_data = b;
    repeat (3) step();
    spi_flag = 0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    reset = 1; spi_flag = 0; frame_tick = 0; move_ready = 0;
    step(); step();
    reset = 0;
    checks++;
    if (move_valid !== 1'b0 || move_code !== 2'd0 || player_angle !== 9'(INIT) ||
        fifo_count !== 3'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_state: got v=%b c=%0d a=%0d n=%0d o=%b d=%0d, want 0 0 %0d 0 0 0",
               move_valid, move_code, player_angle, fifo_count, overflow, drop_count, INIT);
    end
  endtask

  task automatic test_turn_left();
    do_reset();
    spi_flag = 1; spi_data = 8'd3;
    step(); step(); step();
    checks++;
    if (fifo_count !== 3'd1) begin
      failures++; $display("FAIL turn_latency_count: got %0d want 1", fifo_count);
    end
    step();
    checks++;
    if (player_angle !== 9'd504 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL turn_left_wrap: got angle=%0d count=%0d want 504 0", player_angle, fifo_count);
    end
    spi_flag = 0; step(); step();
  endtask

  task automatic test_move_hold();
    int bad = 0;
    do_reset();
    move_ready = 0;
    send_byte(8'd1);
    for (int i = 0; i < 5; i++) begin
      if (move_valid !== 1'b1 || move_code !== 2'd1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++; $display("FAIL move_hold: %0d cycles not valid/code1, want 0", bad);
    end
    move_ready = 1; step(); move_ready = 0;
    checks++;
    if (move_valid !== 1'b0 || move_code !== 2'd0) begin
      failures++;
      $display("FAIL move_accept: got v=%b c=%0d want 0 0", move_valid, move_code);
    end
  endtask

  task automatic test_credit();
    do_reset();
    send_byte(8'd4); send_byte(8'd4); send_byte(8'd4);
    step(); step();
    checks++;
    if (player_angle !== 9'd16 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL credit_limit: got angle=%0d count=%0d want 16 1", player_angle, fifo_count);
    end
    frame_tick = 1; step(); frame_tick = 0;
    step(); step();
    checks++;
    if (player_angle !== 9'd24 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL credit_reload: got angle=%0d count=%0d want 24 0", player_angle, fifo_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    move_ready = 0;
    send_byte(8'd1);
    for (int i = 0; i < 5; i++) send_byte(8'd3);
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1 || drop_count !== 8'd1 || move_valid !== 1'b1) begin
      failures++;
      $display("FAIL overflow: got count=%0d ovf=%b drops=%0d v=%b want 4 1 1 1",
               fifo_count, overflow, drop_count, move_valid);
    end
  endtask

  task automatic test_unknown();
    do_reset();
    send_byte(8'd3);
    send_byte(8'd9);
    send_byte(8'd2);
    checks++;
    if (drop_count !== 8'd1 || move_valid !== 1'b1 || move_code !== 2'd2) begin
      failures++;
      $display("FAIL unknown_code: got drops=%0d v=%b c=%0d want 1 1 2",
               drop_count, move_valid, move_code);
    end
    move_ready = 1; step(); move_ready = 0;
    send_byte(8'd4);
    checks++;
    if (player_angle !== 9'd504 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL credit_exhausted: got angle=%0d count=%0d want 504 1", player_angle, fifo_count);
    end
  endtask

  task automatic test_reset_mid_move();
    int issued = 0;
    do_reset();
    move_ready = 0;
    send_byte(8'd1); send_byte(8'd3); send_byte(8'd3);
    checks++;
    if (fifo_count !== 3'd2 || move_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_move_setup: got count=%0d v=%b want 2 1", fifo_count, move_valid);
    end
    reset = 1; step(); reset = 0;
    checks++;
    if (move_valid !== 1'b0 || fifo_count !== 3'd0 || player_angle !== 9'(INIT)) begin
      failures++;
      $display("FAIL mid_move_reset: got v=%b count=%0d angle=%0d want 0 0 %0d",
               move_valid, fifo_count, player_angle, INIT);
    end
    move_ready = 1;
    repeat (10) begin step(); if (move_valid !== 1'b0) issued++; end
    move_ready = 0;
    checks++;
    if (issued != 0) begin
      failures++; $display("FAIL post_reset_idle: got %0d valid cycles want 0", issued);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (spi_flag) begin
        if ($urandom_range(0, 2) == 0) spi_flag = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        spi_data = 8'($urandom_range(0, 6));
        spi_flag = 1;
      end
      frame_tick = ($urandom_range(0, 15) == 0);
      move_ready = ($urandom_range(0, 2) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      step();
      checks++;
      if (move_valid !== 1'(m_moving) || move_code !== 2'(m_code)) begin
        failures++;
        $display("FAIL rand_move cyc=%0d: got v=%b c=%0d want v=%0d c=%0d",
                 i, move_valid, move_code, m_moving, m_code);
      end
      checks++;
      if (player_angle !== 9'(m_angle) || fifo_count !== 3'(mq.size())) begin
        failures++;
        $display("FAIL rand_state cyc=%0d: got angle=%0d count=%0d want %0d %0d",
                 i, player_angle, fifo_count, m_angle, mq.size());
      end
      checks++;
      if (overflow !== 1'(m_ovf) || drop_count !== 8'(m_drops)) begin
        failures++;
        $display("FAIL rand_drops cyc=%0d: got ovf=%b drops=%0d want %0d %0d",
                 i, overflow, drop_count, m_ovf, m_drops);
      end
    end
    reset = 0; frame_tick = 0; spi_flag = 0; move_ready = 0;
  endtask

  initial begin
    test_reset();
    test_turn_left();
    test_move_hold();
    test_credit();
    test_overflow();
    test_unknown();
    test_reset_mid_move();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
